// File: rtl/vga_sprite_frame.sv
// Tile-map background plus NUM_SPRITES tile-aligned sprite layers, composited per pixel.
// Sprite positions, enables and blink flags are latched once per frame on i_frame_start.
module vga_sprite_frame_rom #(
  parameter int          AW          = 8,
  parameter int          LAT         = 1,
  parameter int          TILE_LOG2   = 4,
  parameter bit          IS_SPRITE   = 1'b0,
  parameter logic [11:0] SEED        = 12'h000,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  output logic [11:0]   o_data
);
  // Image contents are a fixed function of the address, varied by the image-name seed.
  // Sprite k: texel (0,0) and texels with (sx ^ sy) == k are see-through.
  function automatic logic [11:0] f_word(input logic [31:0] a);
    logic [31:0] mask, sx, sy, k;
    mask = (32'd1 << TILE_LOG2) - 32'd1;
    sx   = a & mask;
    sy   = (a >> TILE_LOG2) & mask;
    k    = a >> (2 * TILE_LOG2);
    if (!IS_SPRITE)
      f_word = 12'(a * 32'd7) ^ SEED;
    else if (((sx == 32'd0) && (sy == 32'd0)) || ((sx ^ sy) == (k & mask)))
      f_word = TRANSPARENT;
    else
      f_word = 12'(a) ^ {4'h0, SEED[7:0]};
  endfunction

  logic [11:0] r_data [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_data[i] <= '0;
    end else begin
      if (i_en) r_data[0] <= f_word(32'(i_addr));
      for (int i = 1; i < LAT; i++) r_data[i] <= r_data[i-1];
    end
  end

  assign o_data = r_data[LAT-1];
endmodule

module vga_sprite_frame #(
  parameter int           TILE_LOG2     = 4,
  parameter int           MAP_COLS_LOG2 = 6,
  parameter int           MAP_ROWS_LOG2 = 5,
  parameter int           NUM_SPRITES   = 2,
  parameter int           ROM_LAT       = 1,
  parameter logic [11:0]  TRANSPARENT   = 12'hF0F,
  parameter int           BLINK_LOG2    = 5,
  parameter logic [127:0] MAP_FILE      = "maze1.rom",
  parameter logic [127:0] SPRITE_FILE   = "sprites.rom"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_pix_valid,
  input  logic [9:0]               i_col,
  input  logic [9:0]               i_row,
  input  logic                     i_frame_start,
  input  logic [6*NUM_SPRITES-1:0] i_spr_bcol,
  input  logic [6*NUM_SPRITES-1:0] i_spr_brow,
  input  logic [NUM_SPRITES-1:0]   i_spr_en,
  input  logic [NUM_SPRITES-1:0]   i_spr_blink,
  output logic                     o_pix_valid,
  output logic [3:0]               o_red,
  output logic [3:0]               o_green,
  output logic [3:0]               o_blue
);
  localparam int NS  = NUM_SPRITES;
  localparam int MAW = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
  localparam int SAW = $clog2(NS) + 2 * TILE_LOG2;
  localparam int SBW = NS + 2;
  localparam logic [11:0] MAP_SEED = MAP_FILE[11:0];
  localparam logic [11:0] SPR_SEED = SPRITE_FILE[11:0];

  logic [6*NS-1:0]       r_bcol, r_brow;
  logic [NS-1:0]         r_en, r_blink;
  logic [BLINK_LOG2-1:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcol      <= '0;
      r_brow      <= '0;
      r_en        <= '0;
      r_blink     <= '0;
      r_frame_cnt <= '0;
    end else if (i_frame_start) begin
      r_bcol      <= i_spr_bcol;
      r_brow      <= i_spr_brow;
      r_en        <= i_spr_en;
      r_blink     <= i_spr_blink;
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Stage 0: tile decode, ROM addressing and sprite hit tests
  logic [9:0]             w_tc, w_tr;
  logic [2*TILE_LOG2-1:0] w_local;
  logic [MAW-1:0]         w_bg_addr;
  logic                   w_oob, w_blink_off;
  logic [NS-1:0]          w_hit;
  logic [11:0]            w_texel [NS];
  logic [11:0]            w_bg;

  assign w_tc        = i_col >> TILE_LOG2;
  assign w_tr        = i_row >> TILE_LOG2;
  assign w_local     = {i_row[TILE_LOG2-1:0], i_col[TILE_LOG2-1:0]};
  assign w_bg_addr   = MAW'(w_tc) + (MAW'(w_tr) << MAP_COLS_LOG2);
  assign w_oob       = (32'(w_tc) >= (32'd1 << MAP_COLS_LOG2)) ||
                       (32'(w_tr) >= (32'd1 << MAP_ROWS_LOG2));
  assign w_blink_off = r_frame_cnt[BLINK_LOG2-1];

  vga_sprite_frame_rom #(
    .AW(MAW), .LAT(ROM_LAT), .TILE_LOG2(TILE_LOG2), .IS_SPRITE(1'b0),
    .SEED(MAP_SEED), .TRANSPARENT(TRANSPARENT)
  ) u_bg_rom (
    .clk(clk), .rst_n(rst_n), .i_en(i_pix_valid), .i_addr(w_bg_addr), .o_data(w_bg)
  );

  for (genvar k = 0; k < NS; k++) begin : g_spr
    assign w_hit[k] = r_en[k] && !(r_blink[k] && w_blink_off) &&
                      (w_tc == 10'(r_bcol[6*k +: 6])) && (w_tr == 10'(r_brow[6*k +: 6]));

    vga_sprite_frame_rom #(
      .AW(SAW), .LAT(ROM_LAT), .TILE_LOG2(TILE_LOG2), .IS_SPRITE(1'b1),
      .SEED(SPR_SEED), .TRANSPARENT(TRANSPARENT)
    ) u_spr_rom (
      .clk(clk), .rst_n(rst_n), .i_en(i_pix_valid),
      .i_addr(SAW'(k << (2 * TILE_LOG2)) + SAW'(w_local)), .o_data(w_texel[k])
    );
  end

  // Sideband delay: {oob, hit, valid} aligned with ROM read data
  logic [SBW-1:0] r_sb [ROM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) r_sb[i] <= '0;
    end else begin
      r_sb[0] <= {w_oob, w_hit, i_pix_valid};
      for (int i = 1; i < ROM_LAT; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  logic [SBW-1:0] w_sb;
  logic [11:0]    w_rgb;
  logic           r_vld;
  logic [11:0]    r_rgb;

  assign w_sb = r_sb[ROM_LAT-1];

  // Compose: walk from lowest priority up so sprite 0 is applied last
  always_comb begin
    w_rgb = '0;
    if (w_sb[0] && !w_sb[SBW-1]) begin
      w_rgb = w_bg;
      for (int k = NS - 1; k >= 0; k--)
        if (w_sb[k+1] && (w_texel[k] != TRANSPARENT)) w_rgb = w_texel[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_vld <= w_sb[0];
      r_rgb <= w_rgb;
    end
  end

  assign o_pix_valid = r_vld;
  assign o_red       = r_rgb[11:8];
  assign o_green     = r_rgb[7:4];
  assign o_blue      = r_rgb[3:0];
endmodule

// File: tb/tb_vga_sprite_frame.sv
// Directed bench for vga_sprite_frame (32x32-tile map, two sprites, default image names).
module tb_vga_sprite_frame;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_pix_valid = 1'b0;
  logic [9:0]  i_col = '0;
  logic [9:0]  i_row = '0;
  logic        i_frame_start = 1'b0;
  logic [11:0] i_spr_bcol = '0;
  logic [11:0] i_spr_brow = '0;
  logic [1:0]  i_spr_en = '0;
  logic [1:0]  i_spr_blink = '0;
  logic        o_pix_valid;
  logic [3:0]  o_red, o_green, o_blue;

  int checks = 0;
  int failures = 0;

  vga_sprite_frame #(.MAP_COLS_LOG2(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_pix_valid(i_pix_valid), .i_col(i_col), .i_row(i_row),
    .i_frame_start(i_frame_start), .i_spr_bcol(i_spr_bcol), .i_spr_brow(i_spr_brow),
    .i_spr_en(i_spr_en), .i_spr_blink(i_spr_blink), .o_pix_valid(o_pix_valid),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [5:0]  b0c, b0r, b1c, b1r;
    logic [1:0]  en;
    logic [9:0]  col, row;
    logic        vld;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [12:0] exp);
    logic [12:0] act;
    act = {o_pix_valid, o_red, o_green, o_blue};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got vld/rgb=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [5:0] b0c, b0r, b1c, b1r, input logic [1:0] en, blink);
    i_spr_bcol    = {b1c, b0c};
    i_spr_brow    = {b1r, b0r};
    i_spr_en      = en;
    i_spr_blink   = blink;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  // Present one pixel; its result is visible two edges later.
  task automatic pix(input logic [9:0] col, row, input logic vld);
    i_col = col; i_row = row; i_pix_valid = vld;
    tick();
    i_pix_valid = 1'b0;
    tick();
  endtask

  initial begin
    tbl[0]  = '{"s0 opaque texel 82",     6'd3,  6'd2,  6'd0, 6'd0, 2'b01, 10'd50,  10'd37,  1'b1, {1'b1, 12'h03F}};
    tbl[1]  = '{"s0 clear shows s1",      6'd3,  6'd2,  6'd3, 6'd2, 2'b11, 10'd53,  10'd37,  1'b1, {1'b1, 12'h138}};
    tbl[2]  = '{"both clear shows bg",    6'd3,  6'd2,  6'd3, 6'd2, 2'b11, 10'd48,  10'd32,  1'b1, {1'b1, 12'hEB8}};
    tbl[3]  = '{"s1 alone",               6'd3,  6'd2,  6'd3, 6'd2, 2'b10, 10'd50,  10'd37,  1'b1, {1'b1, 12'h13F}};
    tbl[4]  = '{"s0 priority over s1",    6'd3,  6'd2,  6'd3, 6'd2, 2'b11, 10'd51,  10'd34,  1'b1, {1'b1, 12'h04E}};
    tbl[5]  = '{"s0 elsewhere s1 hit",    6'd4,  6'd2,  6'd3, 6'd2, 2'b11, 10'd50,  10'd37,  1'b1, {1'b1, 12'h13F}};
    tbl[6]  = '{"bg no sprite tile",      6'd3,  6'd2,  6'd3, 6'd2, 2'b11, 10'd80,  10'd37,  1'b1, {1'b1, 12'hE8E}};
    tbl[7]  = '{"oob column",             6'd3,  6'd2,  6'd3, 6'd2, 2'b11, 10'd520, 10'd0,   1'b1, {1'b1, 12'h000}};
    tbl[8]  = '{"oob row",                6'd3,  6'd2,  6'd3, 6'd2, 2'b11, 10'd0,   10'd512, 1'b1, {1'b1, 12'h000}};
    tbl[9]  = '{"invalid slot black",     6'd3,  6'd2,  6'd3, 6'd2, 2'b11, 10'd50,  10'd37,  1'b0, {1'b0, 12'h000}};
    tbl[10] = '{"last map column",        6'd3,  6'd2,  6'd0, 6'd0, 2'b01, 10'd511, 10'd0,   1'b1, {1'b1, 12'hFB4}};
    tbl[11] = '{"s0 at far tile",         6'd31, 6'd29, 6'd0, 6'd0, 2'b01, 10'd503, 10'd473, 1'b1, {1'b1, 12'h0FA}};
    tbl[12] = '{"s0 beyond map is oob",   6'd35, 6'd2,  6'd0, 6'd0, 2'b01, 10'd561, 10'd37,  1'b1, {1'b1, 12'h000}};

    tick(); tick();
    check("reset state", 13'h0000);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      cfg(tbl[i].b0c, tbl[i].b0r, tbl[i].b1c, tbl[i].b1r, tbl[i].en, 2'b00);
      pix(tbl[i].col, tbl[i].row, tbl[i].vld);
      check(tbl[i].nm, tbl[i].exp);
    end

    // Frame latching: input moves only take effect at the next frame start
    cfg(6'd3, 6'd2, 6'd0, 6'd0, 2'b01, 2'b00);
    i_spr_bcol[5:0] = 6'd4;
    pix(10'd50, 10'd37, 1'b1);
    check("latch keeps old tile", {1'b1, 12'h03F});
    pix(10'd66, 10'd37, 1'b1);
    check("latch new tile still bg", {1'b1, 12'hEB1});
    i_col = 10'd50; i_row = 10'd37; i_pix_valid = 1'b1; i_frame_start = 1'b1;
    tick();
    i_pix_valid = 1'b0; i_frame_start = 1'b0;
    tick();
    check("same-cycle start uses old", {1'b1, 12'h03F});
    pix(10'd66, 10'd37, 1'b1);
    check("sprite at moved tile", {1'b1, 12'h03F});
    pix(10'd50, 10'd37, 1'b1);
    check("old tile now bg", {1'b1, 12'hEB8});

    // Back-to-back stream with a one-slot gap
    i_col = 10'd66; i_row = 10'd37; i_pix_valid = 1'b1;
    tick();
    i_pix_valid = 1'b0;
    tick();
    check("stream slot A", {1'b1, 12'h03F});
    i_col = 10'd80; i_pix_valid = 1'b1;
    tick();
    check("stream gap slot", 13'h0000);
    i_pix_valid = 1'b0;
    tick();
    check("stream slot C", {1'b1, 12'hE8E});

    // Reset mid-line: async clear, then two-cycle latency from the first pixel after release
    cfg(6'd3, 6'd2, 6'd0, 6'd0, 2'b01, 2'b00);
    i_col = 10'd50; i_row = 10'd37; i_pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("stream before reset", {1'b1, 12'h03F});
    rst_n = 1'b0;
    #1;
    check("async reset clears outputs", 13'h0000);
    #2 rst_n = 1'b1;
    tick();
    check("no output one edge after release", 13'h0000);
    tick();
    check("first pixel after release", {1'b1, 12'hEB8});
    i_pix_valid = 1'b0;
    tick();

    // Blink: counter from reset, visible while its MSB is clear
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int p = 1; p <= 33; p++) begin
      cfg(6'd3, 6'd2, 6'd0, 6'd0, 2'b01, 2'b01);
      if (p == 1 || p == 15 || p == 32 || p == 33) begin
        pix(10'd50, 10'd37, 1'b1);
        check($sformatf("blink on frame %0d", p % 32), {1'b1, 12'h03F});
      end else if (p == 16 || p == 31) begin
        pix(10'd50, 10'd37, 1'b1);
        check($sformatf("blink off frame %0d", p), {1'b1, 12'hEB8});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_sprite_frame.md
Name: vga_sprite_frame

Overview:
- Parametrised successor of the maze frame renderer.
- Composites a tiled background map with NUM_SPRITES tile-aligned sprites per pixel. Sprites support per-sprite enable, blinking and transparency.
- Sits between the VGA timing generator (col/row/valid) and the DAC pins. It owns the background ROM and the sprite ROMs.
- Sprite positions are latched once per frame, so there is no tearing.

Parameters:
- TILE_LOG2, 4, log2 of tile edge in pixels (tile = 16x16).
- MAP_COLS_LOG2, 6, log2 of map width in tiles; background ROM row stride.
- MAP_ROWS_LOG2, 5, log2 of map height in tiles.
- NUM_SPRITES, 2, number of sprite layers; index 0 has highest priority.
- ROM_LAT, 1, read latency in cycles of the rom instances; the sideband pipeline matches it.
- TRANSPARENT, 12'hF0F, 12-bit RGB sprite texel value treated as see-through.
- BLINK_LOG2, 5, blink period is 2^BLINK_LOG2 frames; half on, half off.
- MAP_FILE, "maze1.rom", background ROM image; 2^(MAP_COLS_LOG2+MAP_ROWS_LOG2) words.
- SPRITE_FILE, "sprites.rom", sprite images concatenated; sprite k occupies words k*4^TILE_LOG2 onward.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- i_pix_valid  in  1  visible-area pixel strobe
- i_col  in  10  pixel column
- i_row  in  10  pixel row
- i_frame_start  in  1  one-cycle pulse once per frame, during blanking
- i_spr_bcol  in  6*NUM_SPRITES  sprite tile columns; sprite k at bits [6k+5:6k]
- i_spr_brow  in  6*NUM_SPRITES  sprite tile rows, same packing
- i_spr_en  in  NUM_SPRITES  sprite visible enable
- i_spr_blink  in  NUM_SPRITES  sprite blink enable
- o_pix_valid  out  1  i_pix_valid delayed by ROM_LAT+1
- o_red  out  4  red channel
- o_green  out  4  green channel
- o_blue  out  4  blue channel

Behaviour:
- Reset (rst_n low, asynchronous): the following are all cleared to 0 immediately:
  - o_red, o_green, o_blue, o_pix_valid;
  - all pipeline stages;
  - shadow position, enable and blink registers;
  - frame counter.
  - Rendering resumes on the first valid pixel after release.
- Shadow registers:
  - On the i_frame_start cycle, i_spr_bcol, i_spr_brow, i_spr_en and i_spr_blink are captured.
  - Input changes at any other time have no effect until the next i_frame_start.
  - Pixels presented in the same cycle as i_frame_start use the old shadow values.
- Frame counter:
  - Width BLINK_LOG2; increments on i_frame_start and wraps.
  - blink_off = counter MSB.
  - Sprite k is active iff en[k] && !(blink[k] && blink_off).
- Stage 0 (combinational on inputs):
  - tc = i_col>>TILE_LOG2, tr = i_row>>TILE_LOG2; sx = i_col mod tile, sy = i_row mod tile.
  - Background address = tc + (tr<<MAP_COLS_LOG2).
  - Sprite k address = k*4^TILE_LOG2 + (sy<<TILE_LOG2) + sx (row-major).
  - hit[k] = active[k] && tc==bcol[k] && tr==brow[k].
  - oob = (tc >= 2^MAP_COLS_LOG2) || (tr >= 2^MAP_ROWS_LOG2).
  - All ROM enables = i_pix_valid. One rom instance per sprite, generated, all loaded from SPRITE_FILE.
- Sideband delay line: valid, hit[NUM_SPRITES-1:0] and oob are delayed ROM_LAT cycles to align with ROM data.
- Compose, registered one cycle:
  - If delayed valid is 0, or oob: output 0.
  - Else the lowest k with hit[k] and texel_k[11:0] != TRANSPARENT wins.
  - Else background pixel [11:0].
  - Output mapping: red=[11:8], green=[7:4], blue=[3:0].
- Latency: i_col/i_row/i_pix_valid to outputs = ROM_LAT+1 cycles, constant. Fully pipelined, one pixel per clock; no stalls.
- Sprites on the same tile: priority by index. A transparent texel of the higher-priority sprite shows the lower sprite, else the background.
- i_pix_valid low for a cycle: that slot outputs black with o_pix_valid=0. Neighbouring slots are unaffected.
- Widths: address arithmetic is unsigned and sized to the ROM address width. Position compares are 6-bit against zero-extended tile indices.

Test Plan:
- Reset mid-line: pix stream active, rst_n low at cycle 10 -> o_* and o_pix_valid are 0 in the same cycle; first valid output appears ROM_LAT+1 cycles after the first valid pixel post-release.
- Sprite addressing, defaults: sprite0 at (3,2), en=1; pixel col=50, row=37 -> sprite0 addr 82; after 2 cycles, RGB = sprite texel 82 (non-transparent).
- Transparency and priority: sprite0 and sprite1 both at (3,2). Texel 82 of sprite0 = F0F -> output = sprite1 texel 338. If that is also F0F -> background word 3+(2<<6)=131.
- Frame latching: move sprite0 to (4,2) mid-frame -> the rest of the frame still renders it at (3,2); it appears at (4,2) only after the next i_frame_start.
- Blink: sprite0 blink=1, BLINK_LOG2=5 -> visible for frames 0-15, background shown at its tile for frames 16-31, visible again at frame 32 (wrap).
- Out of map: MAP_COLS_LOG2=5, pixel col=520 (tc=32) valid -> output 0 with o_pix_valid=1.
